// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with per-packet destination lock,
// broadcast mode and a saturating counter of beats dropped on illegal selects.
module demux_stream_1ton #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_last,
  output logic [7:0]                drop_cnt
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      bcast_q, bcast_d;
  logic                      discard_q, discard_d;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic [CHANNELS-1:0]       last_q, last_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [7:0]                drop_q, drop_d;

  logic [SEL_W-1:0]    cur_sel;
  logic                cur_bcast;
  logic                cur_discard;
  logic [CHANNELS-1:0] sel_oh;
  logic [CHANNELS-1:0] can_load;
  logic [CHANNELS-1:0] load;
  logic                dest_ready;
  logic                accept;

  always_comb begin
    cur_sel   = (state_q == IDLE) ? in_sel   : sel_q;
    cur_bcast = (state_q == IDLE) ? in_bcast : bcast_q;

    sel_oh = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(cur_sel) == k) sel_oh[k] = 1'b1;
    end

    // Out-of-range selects have no one-hot bit, which is what marks a discard.
    cur_discard = (state_q == IDLE) ? (!in_bcast && !(|sel_oh)) : discard_q;

    can_load = ~valid_q | out_ready;

    if (cur_bcast)        dest_ready = &can_load;
    else if (cur_discard) dest_ready = 1'b1;
    else                  dest_ready = |(can_load & sel_oh);
  end

  assign in_ready = rst_n && dest_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept && !cur_discard) load = cur_bcast ? '1 : sel_oh;

    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (load[k]) begin
        valid_d[k]               = 1'b1;
        last_d[k]                = in_last;
        data_d[k*WIDTH +: WIDTH] = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    drop_d = drop_q;
    if (accept && cur_discard && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    state_d   = state_q;
    sel_d     = sel_q;
    bcast_d   = bcast_q;
    discard_d = discard_q;
    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
      end else begin
        state_d = PKT;
        if (state_q == IDLE) begin
          sel_d     = in_sel;
          bcast_d   = in_bcast;
          discard_d = cur_discard;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      bcast_q   <= 1'b0;
      discard_q <= 1'b0;
      valid_q   <= '0;
      last_q    <= '0;
      data_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      bcast_q   <= bcast_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: a 4-channel instance for routing,
// back-pressure, broadcast and reset, plus a 3-channel instance for drops.
module tb_demux_stream_1ton;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_last, in_bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in3_valid, in3_ready, in3_last, in3_bcast;
  logic [7:0]  in3_data;
  logic [1:0]  in3_sel;
  logic [2:0]  out3_valid, out3_ready, out3_last;
  logic [23:0] out3_data;
  logic [7:0]  drop3_cnt;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  demux_stream_1ton #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt)
  );

  demux_stream_1ton #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .in_last(in3_last), .in_sel(in3_sel), .in_bcast(in3_bcast),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
    .out_last(out3_last), .drop_cnt(drop3_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic l, input logic b);
    in_valid = v; in_data = d; in_sel = s; in_last = l; in_bcast = b;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic l);
    in3_valid = v; in3_data = d; in3_sel = s; in3_last = l; in3_bcast = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    drive3(1'b0, 8'h00, 2'd0, 1'b0);
    out_ready  = 4'b1111;
    out3_ready = 3'b111;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_drop3_cnt", 32'(drop3_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single-beat packets to each channel back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 2'(i), 1'b1, 1'b0);
      #1 check("t1_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("t1_out_valid", 32'(out_valid), 32'h1 << i);
      check("t1_out_data", 32'(out_data[i*8 +: 8]), 32'h11 + 32'(i));
      check("t1_out_last", 32'(out_last[i]), 32'h1);
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    check("t1_idle", 32'(out_valid), 32'h0);

    // 2: destination locked for the whole packet despite in_sel changing
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), (i == 0) ? 2'd2 : 2'd1, (i == 2), 1'b0);
      tick();
      check("t2_out_valid", 32'(out_valid), 32'h4);
      check("t2_out_data", 32'(out_data[23:16]), 32'hA0 + 32'(i));
      check("t2_out_last", 32'(out_last[2]), (i == 2) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();

    // 3: back-pressure on channel 1
    out_ready = 4'b1101;
    drive(1'b1, 8'hB0, 2'd1, 1'b0, 1'b0);
    #1 check("t3_ready_first", 32'(in_ready), 32'h1);
    tick();
    check("t3_valid_first", 32'(out_valid), 32'h2);
    check("t3_data_first", 32'(out_data[15:8]), 32'hB0);
    drive(1'b1, 8'hB1, 2'd1, 1'b1, 1'b0);
    #1 check("t3_ready_stall", 32'(in_ready), 32'h0);
    tick();
    check("t3_hold_data", 32'(out_data[15:8]), 32'hB0);
    check("t3_hold_last", 32'(out_last[1]), 32'h0);
    check("t3_ready_stall2", 32'(in_ready), 32'h0);
    out_ready = 4'b1111;
    #1 check("t3_ready_release", 32'(in_ready), 32'h1);
    tick();
    check("t3_valid_second", 32'(out_valid), 32'h2);
    check("t3_data_second", 32'(out_data[15:8]), 32'hB1);
    check("t3_last_second", 32'(out_last[1]), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    check("t3_drained", 32'(out_valid), 32'h0);

    // 4: broadcast waits for every channel to be loadable
    out_ready = 4'b0111;
    drive(1'b1, 8'hC3, 2'd3, 1'b1, 1'b0);
    tick();
    check("t4_ch3_full", 32'(out_valid), 32'h8);
    drive(1'b1, 8'h5A, 2'd0, 1'b1, 1'b1);
    #1 check("t4_bcast_blocked", 32'(in_ready), 32'h0);
    tick();
    check("t4_bcast_blocked2", 32'(in_ready), 32'h0);
    check("t4_ch3_hold", 32'(out_data[31:24]), 32'hC3);
    out_ready = 4'b1111;
    #1 check("t4_bcast_ready", 32'(in_ready), 32'h1);
    tick();
    check("t4_bcast_valid", 32'(out_valid), 32'hF);
    check("t4_bcast_data", out_data, 32'h5A5A5A5A);
    check("t4_bcast_last", 32'(out_last), 32'hF);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    check("t4_drained", 32'(out_valid), 32'h0);

    // 5: illegal select on the 3-channel build, discard locked for the packet
    drive3(1'b1, 8'hD0, 2'd3, 1'b0);
    #1 check("t5_ready_illegal", 32'(in3_ready), 32'h1);
    tick();
    check("t5_valid_b1", 32'(out3_valid), 32'h0);
    check("t5_drop_b1", 32'(drop3_cnt), 32'h1);
    drive3(1'b1, 8'hD1, 2'd0, 1'b1);
    tick();
    check("t5_valid_b2", 32'(out3_valid), 32'h0);
    check("t5_drop_b2", 32'(drop3_cnt), 32'h2);
    drive3(1'b1, 8'hD2, 2'd3, 1'b1);
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 252) check("t5_drop_reach", 32'(drop3_cnt), 32'd255);
    end
    check("t5_drop_sat", 32'(drop3_cnt), 32'd255);
    check("t5_valid_sat", 32'(out3_valid), 32'h0);
    drive3(1'b1, 8'hD3, 2'd1, 1'b1);
    tick();
    check("t5_legal_after", 32'(out3_valid), 32'h2);
    check("t5_legal_data", 32'(out3_data[15:8]), 32'hD3);
    drive3(1'b0, 8'h00, 2'd0, 1'b0);

    // 6: asynchronous reset mid-packet with channels holding data
    out_ready = 4'b0000;
    drive(1'b1, 8'hE0, 2'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hE2, 2'd2, 1'b0, 1'b0);
    tick();
    check("t6_pre_valid", 32'(out_valid), 32'h5);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_data", out_data, 32'h0);
    check("t6_rst_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 4'b1111;
    drive(1'b1, 8'hE1, 2'd1, 1'b1, 1'b0);
    tick();
    check("t6_post_valid", 32'(out_valid), 32'h2);
    check("t6_post_data", 32'(out_data[15:8]), 32'hE1);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
